xnor_cmp_sched: RTL and testbench
=================================

XNOR_CMP_SCHED -- requirements
Module: xnor_cmp_sched

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port rst_n  input  1  synchronous, active-low reset.
REQ-004 Port req0  input  1  requester 0 request, level.
REQ-005 Port a0, b0  input  WIDTH each  requester 0 operands; held stable while req0 is high.
REQ-006 Port req1  input  1  requester 1 request, level.
REQ-007 Port a1, b1  input  WIDTH each  requester 1 operands; held stable while req1 is high.
REQ-008 Port gnt0, gnt1  output  1 each  one-cycle grant pulse; operands captured that cycle.
REQ-009 Port busy  output  1  high from the grant cycle through the DONE cycle.
REQ-010 Port done  output  1  one-cycle result-valid pulse.
REQ-011 Port done_id  output  1  requester owning the current result (0 or 1).
REQ-012 Port eq  output  1  high when all bits of the compared operands are equal.
REQ-013 Port mask  output  WIDTH  per-bit equality, mask[i] = a[i] XNOR b[i].

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-015 IDLE, no req high: stay in IDLE; gnt0, gnt1, busy and done low.
REQ-016 IDLE, any req high: pulse the winner's gnt, capture its a/b, set owner, clear bit index to 0, go to RUN.
REQ-017 Arbitration SHALL be round-robin on a last_served pointer. Both reqs high: grant the requester not last served. One req high: grant it regardless of the pointer.
REQ-018 The pointer SHALL update to the winner on every grant.
REQ-019 RUN SHALL evaluate one bit per cycle, LSB first, through one shared 1-bit XNOR cell, writing working_mask[index].
REQ-020 RUN at index WIDTH-1: go to DONE; otherwise increment the index.
REQ-021 DONE SHALL, for one cycle:
- assert done;
- drive mask = working_mask, eq = AND-reduce(working_mask), done_id = owner;
- return to IDLE.
REQ-022 Latency: grant in cycle T, RUN during T+1..T+WIDTH, done in T+WIDTH+1.
REQ-023 The earliest next grant is T+WIDTH+2 (one IDLE cycle); throughput is one operation per WIDTH+2 cycles.
REQ-024 mask, eq and done_id SHALL hold their values until the next DONE.
REQ-025 Operands SHALL come only from the captured registers; input changes after the grant have no effect.
REQ-026 req dropped during RUN: the operation completes and done is still issued.
REQ-027 req still high in the IDLE cycle after DONE: a new operation starts (request is level-sensitive); the requester drops req on done to avoid a repeat.
REQ-028 A req arriving during RUN or DONE SHALL wait; nothing is queued beyond the level.

Reset
REQ-029 rst_n low at a clock edge SHALL:
- set the state to IDLE;
- clear index, working_mask and captured operands;
- set last_served = 1, so requester 0 wins first.
REQ-030 Reset values: gnt0=gnt1=busy=done=0, done_id=0, eq=0, mask=0.
REQ-031 Reset during RUN or DONE SHALL abort the operation with no done pulse; requests are honoured from the first cycle after reset releases.

Structure
REQ-032 A shared package SHALL hold the FSM state enum (IDLE, RUN, DONE) and the requester-id constants REQ_ID0=0, REQ_ID1=1.
REQ-033 The shared per-bit XNOR cell SHALL be one instance of the existing sub-module xnor_struct (x, y -> z), driven by the captured operands muxed at the bit index.
REQ-034 No other sub-modules; arbiter, FSM and counter are in xnor_cmp_sched itself; target size 120-400 lines.

Verification (WIDTH=8)
REQ-035 Reset then idle 5 cycles, no req -> all outputs 0, busy never high.
REQ-036 req0=1, a0=8'hA5, b0=8'hA5 at cycle T:
- gnt0 pulses at T;
- done at T+9 with eq=1, mask=8'hFF, done_id=0.
REQ-037 req1 only, a1=8'h3C, b1=8'h0F -> done with eq=0, mask=8'hCC, done_id=1.
REQ-038 req0 and req1 held high continuously from reset -> grants alternate 0,1,0,1, spaced 10 cycles apart.
REQ-039 Operand and req timing:
- change a0 to 8'h00 the cycle after gnt0, and drop req0 mid-RUN;
- result reflects the captured values and done is still issued.
REQ-040 Assert rst_n=0 at RUN index 4 -> no done, outputs reset. A new req0 after release -> normal 10-cycle operation with gnt0 first.

Source files
------------

// File: rtl/xnor_cmp_sched_pkg.sv
// Shared types for the two-requester XNOR comparator scheduler.
package xnor_cmp_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic REQ_ID0 = 1'b0;
  localparam logic REQ_ID1 = 1'b1;

endpackage

// File: rtl/xnor_struct.sv
// Single-bit equality cell built from a gate primitive.
module xnor_struct (
  input  logic x,
  input  logic y,
  output logic z
);

  xnor u_xnor (z, x, y);

endmodule

// File: rtl/xnor_cmp_sched.sv
// Round-robin scheduler that compares one requester's operands bit-serially
// through a single shared XNOR cell and reports the per-bit equality mask.
module xnor_cmp_sched
  import xnor_cmp_sched_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic             eq,
  output logic [WIDTH-1:0] mask
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] cap_a;
  logic [WIDTH-1:0] cap_b;
  logic [WIDTH-1:0] working_mask;
  logic [WIDTH-1:0] mask_hold;
  logic             eq_hold;
  logic             done_id_hold;
  logic             owner;
  logic             last_served;
  logic             winner;
  logic             start;
  logic             bit_z;

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    winner = REQ_ID0;
    if (req0 && req1) winner = (last_served == REQ_ID0) ? REQ_ID1 : REQ_ID0;
    else if (req1)    winner = REQ_ID1;
  end

  // The grant is visible in the same IDLE cycle that captures the operands.
  assign start = rst_n && (state == IDLE) && (req0 || req1);
  assign gnt0  = start && (winner == REQ_ID0);
  assign gnt1  = start && (winner == REQ_ID1);
  assign busy  = rst_n && (start || (state != IDLE));
  assign done  = (state == DONE);

  // Results are live during DONE and then held until the next DONE.
  assign mask    = (state == DONE) ? working_mask  : mask_hold;
  assign eq      = (state == DONE) ? &working_mask : eq_hold;
  assign done_id = (state == DONE) ? owner         : done_id_hold;

  xnor_struct u_cell (
    .x (cap_a[idx]),
    .y (cap_b[idx]),
    .z (bit_z)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      cap_a        <= '0;
      cap_b        <= '0;
      working_mask <= '0;
      mask_hold    <= '0;
      eq_hold      <= 1'b0;
      done_id_hold <= 1'b0;
      owner        <= REQ_ID0;
      last_served  <= REQ_ID1;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            cap_a       <= (winner == REQ_ID1) ? a1 : a0;
            cap_b       <= (winner == REQ_ID1) ? b1 : b0;
            owner       <= winner;
            last_served <= winner;
            idx         <= '0;
            state       <= RUN;
          end
        end
        RUN: begin
          working_mask[idx] <= bit_z;
          if (idx == LAST_IDX) state <= DONE;
          else                 idx   <= idx + 1'b1;
        end
        DONE: begin
          mask_hold    <= working_mask;
          eq_hold      <= &working_mask;
          done_id_hold <= owner;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xnor_cmp_sched.sv
// Scoreboard bench for xnor_cmp_sched at WIDTH=8: expected results are queued
// at grant time and compared when done pulses.
module tb_xnor_cmp_sched;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic       id;
    logic [7:0] mask;
    logic       eq;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req0 = 1'b0;
  logic             req1 = 1'b0;
  logic [WIDTH-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic             gnt0, gnt1, busy, done, done_id, eq;
  logic [WIDTH-1:0] mask;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  exp_t sb[$];

  xnor_cmp_sched #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req0    (req0),
    .a0      (a0),
    .b0      (b0),
    .req1    (req1),
    .a1      (a1),
    .b1      (b1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .eq      (eq),
    .mask    (mask)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic id, input logic [7:0] a, input logic [7:0] b);
    exp_t r;
    r.id   = id;
    r.mask = ~(a ^ b);
    r.eq   = (a == b);
    return r;
  endfunction

  task automatic wait_done(input int limit, output bit seen, output int at_cyc);
    seen   = 1'b0;
    at_cyc = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen   = 1'b1;
        at_cyc = cyc;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({gnt0, gnt1, busy, done, done_id, eq, mask} !== 15'h0) begin
        n_err++;
        $display("FAIL reset_idle[%0d]: outputs=%h required 0", i,
                 {gnt0, gnt1, busy, done, done_id, eq, mask});
      end
    end
  endtask

  // One requester alone; checks grant, latency, result and hold-after-done.
  task automatic test_single(input string name, input logic id,
                             input logic [7:0] a, input logic [7:0] b);
    int   t, td;
    bit   seen;
    exp_t e;
    sb.delete();
    @(posedge clk); #1;
    if (id) begin req1 = 1'b1; a1 = a; b1 = b; end
    else    begin req0 = 1'b1; a0 = a; b0 = b; end
    sb.push_back(model(id, a, b));
    @(negedge clk);
    t = cyc;
    n_cmp++;
    if ({gnt0, gnt1} !== (id ? 2'b01 : 2'b10)) begin
      n_err++;
      $display("FAIL %s_gnt: gnt0/gnt1=%b required %b", name, {gnt0, gnt1}, id ? 2'b01 : 2'b10);
    end
    @(posedge clk); #1 req0 = 1'b0; req1 = 1'b0;
    wait_done(20, seen, td);
    n_cmp++;
    if (!seen || (td - t) != WIDTH + 1) begin
      n_err++;
      $display("FAIL %s_latency: done after %0d cycles (seen=%0b) required %0d", name, td - t, seen, WIDTH + 1);
    end
    if (seen && sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if ({done_id, mask, eq} !== e) begin
        n_err++;
        $display("FAIL %s_result: id/mask/eq=%b/%h/%b required %b/%h/%b",
                 name, done_id, mask, eq, e.id, e.mask, e.eq);
      end
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({done, done_id, mask, eq} !== {1'b0, e}) begin
        n_err++;
        $display("FAIL %s_hold: done/id/mask/eq=%b/%b/%h/%b required 0/%b/%h/%b",
                 name, done, done_id, mask, eq, e.id, e.mask, e.eq);
      end
    end
  endtask

  task automatic test_alternate();
    int   ngnt = 0, ndone = 0, last_t = -1, rel;
    exp_t e;
    sb.delete();
    rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1;
    a0 = 8'h11; b0 = 8'h11; a1 = 8'h12; b1 = 8'h21;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rel = cyc;
    for (int i = 0; i < 60 && ndone < 4; i++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        n_cmp++;
        if ({gnt0, gnt1} !== ((ngnt % 2) ? 2'b01 : 2'b10)) begin
          n_err++;
          $display("FAIL alt_order[%0d]: gnt0/gnt1=%b required %b", ngnt, {gnt0, gnt1},
                   (ngnt % 2) ? 2'b01 : 2'b10);
        end
        n_cmp++;
        if ((ngnt == 0 && cyc != rel) || (ngnt > 0 && cyc - last_t != WIDTH + 2)) begin
          n_err++;
          $display("FAIL alt_spacing[%0d]: grant at cycle %0d, previous %0d, release %0d",
                   ngnt, cyc, last_t, rel);
        end
        last_t = cyc;
        if (ngnt % 2) sb.push_back(model(1'b1, a1, b1));
        else          sb.push_back(model(1'b0, a0, b0));
        ngnt++;
      end
      if (done === 1'b1) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL alt_result[%0d]: done with no grant outstanding", ndone);
        end else begin
          e = sb.pop_front();
          if ({done_id, mask, eq} !== e) begin
            n_err++;
            $display("FAIL alt_result[%0d]: id/mask/eq=%b/%h/%b required %b/%h/%b",
                     ndone, done_id, mask, eq, e.id, e.mask, e.eq);
          end
        end
        ndone++;
      end
    end
    @(posedge clk); #1 req0 = 1'b0; req1 = 1'b0;
    n_cmp++;
    if (ndone != 4 || ngnt != 4) begin
      n_err++;
      $display("FAIL alt_count: grants=%0d dones=%0d required 4/4", ngnt, ndone);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL alt_idle: busy=%b required 0", busy);
    end
  endtask

  task automatic test_operand_hold();
    int   t, td;
    bit   seen;
    exp_t e;
    sb.delete();
    @(posedge clk); #1 req0 = 1'b1; a0 = 8'h5A; b0 = 8'h5A;
    sb.push_back(model(1'b0, 8'h5A, 8'h5A));
    @(negedge clk);
    t = cyc;
    n_cmp++;
    if (gnt0 !== 1'b1) begin
      n_err++;
      $display("FAIL hold_gnt: gnt0=%b required 1", gnt0);
    end
    @(posedge clk); #1 a0 = 8'h00;
    repeat (3) @(posedge clk);
    #1 req0 = 1'b0;
    wait_done(20, seen, td);
    n_cmp++;
    if (!seen || (td - t) != WIDTH + 1) begin
      n_err++;
      $display("FAIL hold_latency: done after %0d cycles (seen=%0b) required %0d", td - t, seen, WIDTH + 1);
    end
    if (seen && sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if ({done_id, mask, eq} !== e) begin
        n_err++;
        $display("FAIL hold_result: id/mask/eq=%b/%h/%b required %b/%h/%b",
                 done_id, mask, eq, e.id, e.mask, e.eq);
      end
    end
  endtask

  task automatic test_reset_abort();
    int ndone = 0;
    sb.delete();
    @(posedge clk); #1 req0 = 1'b1; a0 = 8'hF0; b0 = 8'h0F;
    @(negedge clk);
    n_cmp++;
    if (gnt0 !== 1'b1) begin
      n_err++;
      $display("FAIL abort_gnt: gnt0=%b required 1", gnt0);
    end
    @(posedge clk); #1 req0 = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    if (done === 1'b1) ndone++;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({gnt0, gnt1, busy, done, done_id, eq, mask} !== 15'h0) begin
      n_err++;
      $display("FAIL abort_outputs: outputs=%h required 0", {gnt0, gnt1, busy, done, done_id, eq, mask});
    end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    n_cmp++;
    if (ndone != 0) begin
      n_err++;
      $display("FAIL abort_no_done: %0d cycles with done/busy high, required 0", ndone);
    end
    test_single("post_reset", 1'b0, 8'hC3, 8'hC3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single("match", 1'b0, 8'hA5, 8'hA5);
    test_single("mismatch", 1'b1, 8'h3C, 8'h0F);
    test_alternate();
    test_operand_hold();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
